// File: rtl/sme_pkg.sv
// Shared types and constants for the multi-length string-matching engine.
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SEARCH,
        DONE
    } sme_state_t;

    localparam logic [7:0] WILD_DEF    = 8'h2E;  // '.'
    localparam logic [7:0] SPACE_DEF   = 8'h20;  // ' '
    localparam logic [7:0] CARET_CODE  = 8'h5E;  // '^'
    localparam logic [7:0] DOLLAR_CODE = 8'h24;  // '$'

    // Bits needed to index an array of the given depth (at least 1).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sme_cmp_row.sv
// One candidate position: compares every stored pattern character against
// the string window starting at pos, plus the word-boundary anchor checks.
module sme_cmp_row
    import sme_pkg::*;
#(
    parameter int                STR_MAX = 32,
    parameter int                PAT_MAX = 8,
    parameter int                CHAR_W  = 8,
    parameter logic [CHAR_W-1:0] WILD    = CHAR_W'(WILD_DEF),
    parameter logic [CHAR_W-1:0] SPACE   = CHAR_W'(SPACE_DEF),
    parameter int                IDX_W   = idx_width(STR_MAX),
    parameter int                CNT_W   = cnt_width(STR_MAX),
    parameter int                PLW     = cnt_width(PAT_MAX)
) (
    input  logic [CHAR_W-1:0] str [STR_MAX],
    input  logic [CNT_W-1:0]  str_len,
    input  logic [CHAR_W-1:0] pat [PAT_MAX],
    input  logic [PLW-1:0]    pat_len,
    input  logic              anchor_start,
    input  logic              anchor_end,
    input  logic [IDX_W-1:0]  pos,
    output logic              hit
);

    logic chars_ok;
    logic start_ok;
    logic end_ok;
    int   pos_i;
    int   end_i;

    // Parallel character compare and anchor evaluation for this position.
    always_comb begin
        pos_i    = int'(pos);
        end_i    = int'(pos) + int'(pat_len);
        chars_ok = 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(pat_len)) begin
                if (pos_i + i >= STR_MAX) begin
                    chars_ok = 1'b0;
                end else if (pat[i] != WILD && pat[i] != str[IDX_W'(pos_i + i)]) begin
                    chars_ok = 1'b0;
                end
            end
        end

        start_ok = 1'b1;
        if (anchor_start && pos_i != 0) begin
            start_ok = (str[IDX_W'(pos_i - 1)] == SPACE);
        end

        end_ok = 1'b1;
        if (anchor_end && end_i != int'(str_len)) begin
            if (end_i < STR_MAX && end_i < int'(str_len)) begin
                end_ok = (str[IDX_W'(end_i)] == SPACE);
            end else begin
                end_ok = 1'b0;
            end
        end

        hit = chars_ok & start_ok & end_ok;
    end

endmodule

// File: rtl/sme_multi.sv
// String-matching engine: buffers a string and a pattern, then scans one
// start position per cycle, reporting first match index and match count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a string or pattern run
// LOAD_STR | string run in progress
// LOAD_PAT | pattern run in progress; search is launched when it ends
// SEARCH   | evaluating one candidate position per cycle
// DONE     | result strobe cycle; new input is already accepted here
module sme_multi
    import sme_pkg::*;
#(
    parameter int                STR_MAX = 32,
    parameter int                PAT_MAX = 8,
    parameter int                CHAR_W  = 8,
    parameter logic [CHAR_W-1:0] WILD    = CHAR_W'(WILD_DEF),
    parameter logic [CHAR_W-1:0] SPACE   = CHAR_W'(SPACE_DEF),
    parameter int                IDX_W   = idx_width(STR_MAX),
    parameter int                CNT_W   = cnt_width(STR_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isstring,
    input  logic              ispattern,
    input  logic [CHAR_W-1:0] chardata,
    output logic              out_valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic [CNT_W-1:0]  match_count
);

    localparam int                PLW     = cnt_width(PAT_MAX);
    localparam int                PIW     = idx_width(PAT_MAX);
    localparam logic [CHAR_W-1:0] CARET   = CHAR_W'(CARET_CODE);
    localparam logic [CHAR_W-1:0] DOLLAR  = CHAR_W'(DOLLAR_CODE);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PLW-1:0]    PL_ONE  = PLW'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

    sme_state_t        state;
    sme_state_t        state_next;
    logic [CHAR_W-1:0] str_mem [STR_MAX];
    logic [CHAR_W-1:0] pat_mem [PAT_MAX];
    logic [CNT_W-1:0]  str_len;
    logic [PLW-1:0]    pat_len;
    logic [PLW-1:0]    pat_len_eff;
    logic              anchor_start;
    logic              anchor_end;
    logic              last_dollar;
    logic              last_dollar_stored;
    logic [IDX_W-1:0]  pos;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  n_pos;
    logic [CNT_W-1:0]  hit_count;
    logic              hit_found;
    logic [IDX_W-1:0]  hit_index;
    logic              row_hit;
    logic              pat_empty;
    logic              scan_none;
    logic              scan_last;

    assign out_valid = (state == DONE);

    sme_cmp_row #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX),
        .CHAR_W  (CHAR_W),
        .WILD    (WILD),
        .SPACE   (SPACE),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W),
        .PLW     (PLW)
    ) u_cmp_row (
        .str          (str_mem),
        .str_len      (str_len),
        .pat          (pat_mem),
        .pat_len      (pat_len),
        .anchor_start (anchor_start),
        .anchor_end   (anchor_end),
        .pos          (pos),
        .hit          (row_hit)
    );

    // A trailing '$' is stored provisionally; it is only known to be the
    // end anchor once the run ends, so the effective length drops it here.
    always_comb begin
        pat_len_eff = pat_len - {{(PLW-1){1'b0}}, last_dollar_stored};
        if (int'(pat_len_eff) > int'(str_len)) begin
            n_pos = '0;
        end else begin
            n_pos = CNT_W'(int'(str_len) - int'(pat_len_eff) + 1);
        end
        pat_empty = (pat_len_eff == '0);
        scan_none = (n_pos == '0);
        scan_last = (remaining == CNT_ONE);
    end

    // Next-state decode; isstring outranks ispattern, and any load aborts.
    always_comb begin
        state_next = state;
        if (isstring) begin
            state_next = LOAD_STR;
        end else if (ispattern) begin
            state_next = LOAD_PAT;
        end else begin
            case (state)
                LOAD_STR: state_next = IDLE;
                LOAD_PAT: state_next = (pat_empty || scan_none) ? DONE : SEARCH;
                SEARCH:   state_next = scan_last ? DONE : SEARCH;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Buffers, scan counters and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STR_MAX; i++) str_mem[i] <= '0;
            for (int i = 0; i < PAT_MAX; i++) pat_mem[i] <= '0;
            str_len            <= '0;
            pat_len            <= '0;
            anchor_start       <= 1'b0;
            anchor_end         <= 1'b0;
            last_dollar        <= 1'b0;
            last_dollar_stored <= 1'b0;
            pos                <= '0;
            remaining          <= '0;
            hit_count          <= '0;
            hit_found          <= 1'b0;
            hit_index          <= '0;
            match              <= 1'b0;
            match_index        <= '0;
            match_count        <= '0;
        end else if (isstring) begin
            if (state != LOAD_STR) begin
                str_mem[0] <= chardata;
                str_len    <= CNT_ONE;
            end else if (int'(str_len) < STR_MAX) begin
                str_mem[str_len[IDX_W-1:0]] <= chardata;
                str_len                     <= str_len + CNT_ONE;
            end
        end else if (ispattern) begin
            if (state != LOAD_PAT) begin
                anchor_start <= (chardata == CARET);
                anchor_end   <= 1'b0;
                if (chardata == CARET) begin
                    pat_len            <= '0;
                    last_dollar        <= 1'b0;
                    last_dollar_stored <= 1'b0;
                end else begin
                    pat_mem[0]         <= chardata;
                    pat_len            <= PL_ONE;
                    last_dollar        <= (chardata == DOLLAR);
                    last_dollar_stored <= (chardata == DOLLAR);
                end
            end else begin
                last_dollar <= (chardata == DOLLAR);
                if (int'(pat_len) < PAT_MAX) begin
                    pat_mem[pat_len[PIW-1:0]] <= chardata;
                    pat_len                   <= pat_len + PL_ONE;
                    last_dollar_stored        <= (chardata == DOLLAR);
                end else begin
                    last_dollar_stored <= 1'b0;
                end
            end
        end else if (state == LOAD_PAT) begin
            pat_len            <= pat_len_eff;
            anchor_end         <= last_dollar;
            last_dollar        <= 1'b0;
            last_dollar_stored <= 1'b0;
            pos                <= '0;
            remaining          <= n_pos;
            hit_count          <= '0;
            hit_found          <= 1'b0;
            hit_index          <= '0;
            if (pat_empty) begin
                match       <= 1'b1;
                match_index <= '0;
                match_count <= CNT_ONE;
            end else if (scan_none) begin
                match       <= 1'b0;
                match_index <= '0;
                match_count <= '0;
            end
        end else if (state == SEARCH) begin
            pos       <= pos + IDX_ONE;
            remaining <= remaining - CNT_ONE;
            if (row_hit) begin
                hit_count <= hit_count + CNT_ONE;
                if (!hit_found) begin
                    hit_found <= 1'b1;
                    hit_index <= pos;
                end
            end
            if (scan_last) begin
                match       <= hit_found | row_hit;
                match_index <= hit_found ? hit_index : (row_hit ? pos : '0);
                match_count <= hit_count + (row_hit ? CNT_ONE : '0);
            end
        end
    end

endmodule

// File: tb/tb_sme_multi.sv
// Directed bench for sme_multi: string/pattern loads, anchors, wildcards,
// overflow, empty pattern, back-to-back queries, abort and reset.
module tb_sme_multi;

    logic       clk;
    logic       rst;
    logic       isstring;
    logic       ispattern;
    logic [7:0] chardata;
    logic       out_valid;
    logic       match;
    logic [4:0] match_index;
    logic [5:0] match_count;

    int total = 0;
    int bad   = 0;
    int ov_count = 0;

    sme_multi dut (
        .clk         (clk),
        .rst         (rst),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .chardata    (chardata),
        .out_valid   (out_valid),
        .match       (match),
        .match_index (match_index),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) ov_count++;

    // All tasks start and end just after a falling edge.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            isstring = 1'b1;
            chardata = s[i];
            @(negedge clk);
        end
        isstring = 1'b0;
        chardata = 8'h00;
    endtask

    // Streams a pattern and waits (bounded) for the result strobe.
    // Returns at the falling edge where out_valid is seen; lat = -1 on timeout.
    task automatic do_query(input string pat, output int lat, output logic m,
                            output logic [4:0] ix, output logic [5:0] ct);
        for (int i = 0; i < pat.len(); i++) begin
            ispattern = 1'b1;
            chardata  = pat[i];
            @(negedge clk);
        end
        ispattern = 1'b0;
        chardata  = 8'h00;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        m  = match;
        ix = match_index;
        ct = match_count;
    endtask

    task automatic test_reset;
        rst = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (match !== 1'b0) begin bad++; $display("FAIL rst_match got=%0b want=0", match); end
        total++; if (match_index !== 5'd0) begin bad++; $display("FAIL rst_index got=%0d want=0", match_index); end
        total++; if (match_count !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", match_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_patterns;
        string pats [10] = '{"o", "^wor", "l.o", "d$", "xyz", "l", ".", "^", "o$", "^h"};
        int    el   [10] = '{12, 10, 10, 12, 10, 12, 12, 1, 12, 12};
        int    em   [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        int    ei   [10] = '{4, 6, 2, 10, 0, 2, 0, 0, 4, 0};
        int    ec   [10] = '{2, 1, 1, 1, 0, 3, 11, 1, 1, 1};
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        send_str("hello world");
        for (int t = 0; t < 10; t++) begin
            do_query(pats[t], lat, m, ix, ct);
            total++;
            if (lat != el[t] || m !== em[t][0] || ix !== ei[t][4:0] || ct !== ec[t][5:0]) begin
                bad++;
                $display("FAIL pat_%s got lat=%0d m=%0b idx=%0d cnt=%0d want lat=%0d m=%0d idx=%0d cnt=%0d",
                         pats[t], lat, m, ix, ct, el[t], em[t], ei[t], ec[t]);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL strobe_width_%s got=%0b want=0", pats[t], out_valid); end
        end
    endtask

    task automatic test_pat_overflow;
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        send_str("abcde");
        do_query("abcdefghi", lat, m, ix, ct);
        total++;
        if (lat != 1 || m !== 1'b0 || ix !== 5'd0 || ct !== 6'd0) begin
            bad++;
            $display("FAIL pat_overflow got lat=%0d m=%0b idx=%0d cnt=%0d want lat=1 m=0 idx=0 cnt=0", lat, m, ix, ct);
        end
        @(negedge clk);
    endtask

    task automatic test_str_saturate;
        string pats [4] = '{"cdef", "ef$", "g", "A"};
        int    el   [4] = '{30, 32, 33, 33};
        int    em   [4] = '{1, 1, 0, 1};
        int    ei   [4] = '{28, 30, 0, 0};
        int    ec   [4] = '{1, 1, 0, 1};
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        for (int i = 0; i < 40; i++) begin
            isstring = 1'b1;
            chardata = (i < 26) ? 8'(8'h41 + i) : 8'(8'h61 + i - 26);
            @(negedge clk);
        end
        isstring = 1'b0;
        chardata = 8'h00;
        for (int t = 0; t < 4; t++) begin
            do_query(pats[t], lat, m, ix, ct);
            total++;
            if (lat != el[t] || m !== em[t][0] || ix !== ei[t][4:0] || ct !== ec[t][5:0]) begin
                bad++;
                $display("FAIL sat_%s got lat=%0d m=%0b idx=%0d cnt=%0d want lat=%0d m=%0d idx=%0d cnt=%0d",
                         pats[t], lat, m, ix, ct, el[t], em[t], ei[t], ec[t]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        int ov_before;
        send_str("hello world");
        ov_before = ov_count;
        do_query("o", lat, m, ix, ct);
        total++;
        if (lat != 12 || m !== 1'b1 || ix !== 5'd4 || ct !== 6'd2) begin
            bad++;
            $display("FAIL b2b_first got lat=%0d m=%0b idx=%0d cnt=%0d want lat=12 m=1 idx=4 cnt=2", lat, m, ix, ct);
        end
        do_query("w", lat, m, ix, ct);
        total++;
        if (lat != 12 || m !== 1'b1 || ix !== 5'd6 || ct !== 6'd1) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d m=%0b idx=%0d cnt=%0d want lat=12 m=1 idx=6 cnt=1", lat, m, ix, ct);
        end
        @(negedge clk);
        total++;
        if (ov_count - ov_before != 2) begin
            bad++;
            $display("FAIL b2b_strobes got=%0d want=2", ov_count - ov_before);
        end
    endtask

    task automatic test_abort;
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        int ov_before;
        ov_before = ov_count;
        ispattern = 1'b1; chardata = "o"; @(negedge clk);
        ispattern = 1'b0; chardata = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (match !== 1'b1 || match_index !== 5'd6 || match_count !== 6'd1) begin
            bad++;
            $display("FAIL abort_hold got m=%0b idx=%0d cnt=%0d want m=1 idx=6 cnt=1", match, match_index, match_count);
        end
        send_str("abcabc");
        repeat (12) @(negedge clk);
        total++;
        if (ov_count != ov_before) begin
            bad++;
            $display("FAIL abort_no_strobe got=%0d want=0", ov_count - ov_before);
        end
        do_query("bc", lat, m, ix, ct);
        total++;
        if (lat != 6 || m !== 1'b1 || ix !== 5'd1 || ct !== 6'd2) begin
            bad++;
            $display("FAIL abort_next got lat=%0d m=%0b idx=%0d cnt=%0d want lat=6 m=1 idx=1 cnt=2", lat, m, ix, ct);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_search;
        int lat; logic m; logic [4:0] ix; logic [5:0] ct;
        int ov_before;
        send_str("hello world");
        ispattern = 1'b1; chardata = "o"; @(negedge clk);
        ispattern = 1'b0; chardata = 8'h00;
        repeat (4) @(negedge clk);
        ov_before = ov_count;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0 || match_count !== 6'd0) begin
            bad++;
            $display("FAIL midrst_outputs got v=%0b m=%0b idx=%0d cnt=%0d want all 0",
                     out_valid, match, match_index, match_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        total++;
        if (ov_count != ov_before) begin
            bad++;
            $display("FAIL midrst_no_strobe got=%0d want=0", ov_count - ov_before);
        end
        do_query("o", lat, m, ix, ct);
        total++;
        if (lat != 1 || m !== 1'b0 || ix !== 5'd0 || ct !== 6'd0) begin
            bad++;
            $display("FAIL midrst_empty_str got lat=%0d m=%0b idx=%0d cnt=%0d want lat=1 m=0 idx=0 cnt=0", lat, m, ix, ct);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_pat_overflow();
        test_str_saturate();
        test_back_to_back();
        test_abort();
        test_reset_mid_search();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
